// File: rtl/npu_actfun_pkg.sv
// Shared encodings for the activation write-back engine: activation modes,
// controller states and the element-count decode.
package npu_actfun_pkg;

    typedef logic [1:0] act_mode_t;

    localparam act_mode_t ACT_BYPASS = 2'b00;
    localparam act_mode_t ACT_RELU   = 2'b01;
    localparam act_mode_t ACT_LEAKY  = 2'b10;
    localparam act_mode_t ACT_CLIP   = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // An 8-bit piece count of zero stands for a full 256-element job.
    function automatic logic [8:0] piece_target(input logic [7:0] n);
        return (n == 8'd0) ? 9'd256 : {1'b0, n};
    endfunction

endpackage

// File: rtl/actfun_alu.sv
// Per-element activation function, purely combinational, all values treated
// as signed DATA_W integers.
module actfun_alu
    import npu_actfun_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] i_x,
    input  logic [1:0]        i_mode,
    input  logic [2:0]        i_shift,
    input  logic [DATA_W-1:0] i_clip,
    output logic [DATA_W-1:0] o_y
);

    logic signed [DATA_W-1:0] x_s;
    logic signed [DATA_W-1:0] clip_s;
    logic signed [DATA_W-1:0] y_s;

    // A negative ceiling would make clipping meaningless, so it floors at zero.
    assign x_s    = i_x;
    assign clip_s = i_clip[DATA_W-1] ? '0 : i_clip;

    always_comb begin
        y_s = x_s;
        case (i_mode)
            ACT_RELU: begin
                if (x_s < 0) y_s = '0;
            end
            ACT_LEAKY: begin
                if (x_s < 0) y_s = x_s >>> i_shift;
            end
            ACT_CLIP: begin
                if (x_s < 0)           y_s = '0;
                else if (x_s > clip_s) y_s = clip_s;
            end
            default: y_s = x_s;
        endcase
    end

    assign o_y = y_s;

endmodule

// File: rtl/actfun_wb.sv
// Activation write-back engine: takes IOB read data one cycle after the read
// enable, applies the latched activation and writes it back sequentially.
module actfun_wb
    import npu_actfun_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_AGUStart,
    input  logic [ADDR_W-1:0] i_addr_wstart,
    input  logic [7:0]        i_i_piece_num,
    input  logic [1:0]        i_act_mode,
    input  logic [2:0]        i_leak_shift,
    input  logic [DATA_W-1:0] i_clip,
    input  logic              i_IOB_REn,
    input  logic [DATA_W-1:0] i_IOB_RData,
    output logic              o_IOB_WEn,
    output logic [ADDR_W-1:0] o_IOB_WAddr,
    output logic [DATA_W-1:0] o_IOB_WData,
    output logic              o_busy,
    output logic              o_done
);

    logic [1:0]        state_q,    state_d;
    logic [8:0]        tgt_q,      tgt_d;
    logic [1:0]        mode_q,     mode_d;
    logic [2:0]        shift_q,    shift_d;
    logic [DATA_W-1:0] clip_q,     clip_d;
    logic [8:0]        acc_cnt_q,  acc_cnt_d;
    logic [8:0]        wr_cnt_q,   wr_cnt_d;
    logic              s1_valid_q, s1_valid_d;
    logic              wen_q,      wen_d;
    logic [ADDR_W-1:0] waddr_q,    waddr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;

    logic              accept;
    logic [DATA_W-1:0] alu_y;

    // The returning read data arrives while stage 1 is valid and is activated
    // straight into the output register, giving REn-to-WEn latency of two.
    actfun_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_x     (i_IOB_RData),
        .i_mode  (mode_q),
        .i_shift (shift_q),
        .i_clip  (clip_q),
        .o_y     (alu_y)
    );

    // Reads are only honoured while running, never on a start cycle, and never
    // beyond the job's element count.
    assign accept = (state_q == ST_RUN) && !i_AGUStart && i_IOB_REn
                    && (acc_cnt_q < tgt_q);

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        mode_d     = mode_q;
        shift_d    = shift_q;
        clip_d     = clip_q;
        acc_cnt_d  = acc_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        s1_valid_d = accept;
        wen_d      = s1_valid_q && !i_AGUStart;
        waddr_d    = wen_q ? waddr_q + 1'b1 : waddr_q;
        wdata_d    = wdata_q;

        if (wen_d) begin
            wdata_d  = alu_y;
            wr_cnt_d = wr_cnt_q + 9'd1;
        end
        if (accept) begin
            acc_cnt_d = acc_cnt_q + 9'd1;
        end

        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_RUN:  state_d = (wr_cnt_q == tgt_q) ? ST_DONE : ST_RUN;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A start in any state reloads the job and discards whatever is in flight.
        if (i_AGUStart) begin
            state_d   = ST_RUN;
            tgt_d     = piece_target(i_i_piece_num);
            mode_d    = i_act_mode;
            shift_d   = i_leak_shift;
            clip_d    = i_clip;
            acc_cnt_d = '0;
            wr_cnt_d  = '0;
            waddr_d   = i_addr_wstart;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            tgt_q      <= '0;
            mode_q     <= ACT_BYPASS;
            shift_q    <= '0;
            clip_q     <= '0;
            acc_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            s1_valid_q <= 1'b0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            mode_q     <= mode_d;
            shift_q    <= shift_d;
            clip_q     <= clip_d;
            acc_cnt_q  <= acc_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            s1_valid_q <= s1_valid_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign o_IOB_WEn   = wen_q;
    assign o_IOB_WAddr = waddr_q;
    assign o_IOB_WData = wdata_q;
    assign o_busy      = (state_q == ST_RUN);
    assign o_done      = (state_q == ST_DONE);

endmodule
